// File: rtl/imem_arbiter_pkg.sv
// Shared instruction/data memory definitions: FSM state encoding, default widths
// and the byte-address legality check used by both memory-side arbiters.
package imem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Word-aligned and inside a RAM of 2**aw words.
  function automatic logic addr_legal(input logic [31:0] addr, input int aw);
    logic [31:0] w_hi;
    w_hi = addr >> (aw + 2);
    return (addr[1:0] == 2'b00) && (w_hi == 32'd0);
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_guard.sv
// Starvation guard for the fetch port: counts back-to-back loader grants while
// fetch is waiting and forces a fetch win once the run limit is reached.
module imem_rr_guard
  import imem_pkg::*;
#(
  parameter int MAX_LD_RUN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_f_req,
  input  logic i_ld_gnt_legal,
  input  logic i_f_gnt,
  output logic o_fetch_wins
);

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_LD_RUN);

  logic [3:0] r_ld_run_cnt;

  assign o_fetch_wins = i_run && i_f_req && (r_ld_run_cnt == RUN_LIMIT);

  // Illegal loader accesses never reach i_ld_gnt_legal, so they do not count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ld_run_cnt <= '0;
    end else if (!i_run || !i_f_req || i_f_gnt) begin
      r_ld_run_cnt <= '0;
    end else if (i_ld_gnt_legal && (r_ld_run_cnt != RUN_LIMIT)) begin
      r_ld_run_cnt <= r_ld_run_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction RAM arbiter: loader-only BOOT phase, loader/fetch sharing in RUN
// with a starvation guard, and a sticky HALT on illegal fetch addresses.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_LD_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              cpu_hold,
  output logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              r_state;
  state_t              w_next;
  logic                r_cpu_hold;
  logic                r_ld_pend;
  logic                r_f_pend;
  logic [DATA_W-1:0]   r_ld_hold;
  logic [DATA_W-1:0]   r_f_hold;

  logic                w_ld_legal;
  logic                w_f_legal;
  logic                w_fetch_wins;
  logic                w_sel_ld;
  logic                w_sel_f;
  logic                w_ld_gnt;
  logic                w_ld_err;
  logic                w_f_gnt;
  logic                w_mem_en;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  assign w_ld_legal = addr_legal(ld_addr, ADDR_W);
  assign w_f_legal  = addr_legal(f_addr, ADDR_W);

  imem_rr_guard #(
    .MAX_LD_RUN(MAX_LD_RUN)
  ) u_rr_guard (
    .i_clk         (clk),
    .i_rst         (reset),
    .i_run         (r_state == ST_RUN),
    .i_f_req       (f_req),
    .i_ld_gnt_legal(w_ld_gnt && w_ld_legal),
    .i_f_gnt       (w_f_gnt),
    .o_fetch_wins  (w_fetch_wins)
  );

  // Nothing is granted while reset is held, so the RAM never sees a stray access.
  always_comb begin
    w_next      = r_state;
    w_sel_ld    = 1'b0;
    w_sel_f     = 1'b0;
    w_ld_gnt    = 1'b0;
    w_ld_err    = 1'b0;
    w_f_gnt     = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (!reset) begin
      unique case (r_state)
        ST_BOOT: begin
          w_sel_ld = ld_req;
          if (ld_done) w_next = ST_RUN;
        end
        ST_RUN: begin
          if (w_fetch_wins)  w_sel_f  = 1'b1;
          else if (ld_req)   w_sel_ld = 1'b1;
          else if (f_req)    w_sel_f  = 1'b1;
        end
        ST_HALT: w_sel_ld = ld_req;
        default: w_next = ST_BOOT;
      endcase

      if (w_sel_ld) begin
        w_ld_gnt = 1'b1;
        w_ld_err = !w_ld_legal;
        if (w_ld_legal) begin
          w_mem_en   = 1'b1;
          w_mem_we   = ld_we;
          w_mem_addr = ld_addr[ADDR_W+1:2];
          if (ld_we) w_mem_wdata = ld_wdata;
        end
      end

      if (w_sel_f) begin
        if (w_f_legal) begin
          w_f_gnt    = 1'b1;
          w_mem_en   = 1'b1;
          w_mem_addr = f_addr[ADDR_W+1:2];
        end else begin
          w_next = ST_HALT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_BOOT;
      r_cpu_hold <= 1'b1;
      r_ld_pend  <= 1'b0;
      r_f_pend   <= 1'b0;
      r_ld_hold  <= '0;
      r_f_hold   <= '0;
    end else begin
      r_state    <= w_next;
      r_cpu_hold <= (w_next != ST_RUN);
      r_ld_pend  <= w_ld_gnt && w_mem_en && !w_mem_we;
      r_f_pend   <= w_f_gnt;
      if (r_ld_pend) r_ld_hold <= mem_rdata;
      if (r_f_pend)  r_f_hold  <= mem_rdata;
    end
  end

  // RAM data arrives in the rvalid cycle; the hold registers keep it afterwards.
  assign ld_rvalid = r_ld_pend;
  assign f_rvalid  = r_f_pend;
  assign ld_rdata  = r_ld_pend ? mem_rdata : r_ld_hold;
  assign f_rdata   = r_f_pend  ? mem_rdata : r_f_hold;

  assign ld_gnt    = w_ld_gnt;
  assign ld_err    = w_ld_err;
  assign f_gnt     = w_f_gnt;
  assign mem_en    = w_mem_en;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter with a behavioural RAM and an
// abstract reference model of the boot/run/halt sharing rules.
module tb_imem_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int MAXR  = 4;
  localparam int DEPTH = 1 << AW;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_req, ld_we, ld_done, f_req;
  logic [31:0]   ld_addr, f_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt, ld_rvalid, ld_err, f_gnt, f_rvalid, cpu_hold, halted;
  logic          mem_en, mem_we;
  logic [DW-1:0] ld_rdata, f_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LD_RUN(MAXR)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ld_err(ld_err), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .cpu_hold(cpu_hold), .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM macro, not affected by reset.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  typedef struct {
    logic [31:0] ld_gnt, f_gnt, ld_err, mem_en, mem_we, addr, wdata;
    logic [31:0] hold, halted, ld_rv, f_rv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] f_q[$];
  exp_t        mon_e;

  int          m_mode;
  int          m_streak;
  bit          m_ld_pend, m_f_pend;
  logic [31:0] m_mem [DEPTH];

  int n_vec  = 0;
  int n_bad  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic bit m_legal(logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(4 * DEPTH));
  endfunction

  // Reference model: decide who is served this cycle from the mode and the
  // number of loader wins in a row, then record the expected response.
  task automatic step(bit lr, bit lw, logic [31:0] la, logic [31:0] lwd,
                      bit ldn, bit fr, logic [31:0] fa);
    exp_t e;
    bit   sel_l, sel_f;
    int   nxt;
    @(posedge clk);
    #1;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd; ld_done = ldn;
    f_req = fr; f_addr = fa;
    e = '{default: 0};
    e.hold   = (m_mode != M_RUN) ? 1 : 0;
    e.halted = (m_mode == M_HALT) ? 1 : 0;
    e.ld_rv  = m_ld_pend ? 1 : 0;
    e.f_rv   = m_f_pend ? 1 : 0;
    m_ld_pend = 0;
    m_f_pend  = 0;
    sel_l = 0;
    sel_f = 0;
    nxt   = m_mode;
    if (m_mode == M_RUN) begin
      if (fr && m_streak == MAXR) sel_f = 1;
      else if (lr)                sel_l = 1;
      else if (fr)                sel_f = 1;
    end else begin
      sel_l = lr;
      if (m_mode == M_BOOT && ldn) nxt = M_RUN;
    end
    if (sel_l) begin
      e.ld_gnt = 1;
      if (!m_legal(la)) e.ld_err = 1;
      else begin
        e.mem_en = 1;
        e.addr   = la / 4;
        if (lw) begin
          e.mem_we = 1;
          e.wdata  = lwd;
          m_mem[la / 4] = lwd;
        end else begin
          ld_q.push_back(m_mem[la / 4]);
          m_ld_pend = 1;
        end
      end
    end
    if (sel_f) begin
      if (m_legal(fa)) begin
        e.f_gnt  = 1;
        e.mem_en = 1;
        e.addr   = fa / 4;
        f_q.push_back(m_mem[fa / 4]);
        m_f_pend = 1;
      end else nxt = M_HALT;
    end
    if (m_mode != M_RUN || !fr || sel_f) m_streak = 0;
    else if (sel_l && m_legal(la))       m_streak++;
    m_mode = nxt;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    ld_q.delete();
    f_q.delete();
    m_mode = M_BOOT;
    m_streak = 0;
    m_ld_pend = 0;
    m_f_pend = 0;
  endtask

  task automatic zero_inputs();
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_done = 0;
    f_req = 0; f_addr = 0;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    zero_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  function automatic logic [31:0] rnd_word_addr();
    return 32'($urandom_range(0, DEPTH - 1)) << 2;
  endfunction

  // Monitor: compares every recorded cycle and pops read data on each rvalid.
  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ld_gnt",    32'(ld_gnt),    mon_e.ld_gnt);
      chk("ld_err",    32'(ld_err),    mon_e.ld_err);
      chk("f_gnt",     32'(f_gnt),     mon_e.f_gnt);
      chk("mem_en",    32'(mem_en),    mon_e.mem_en);
      chk("cpu_hold",  32'(cpu_hold),  mon_e.hold);
      chk("halted",    32'(halted),    mon_e.halted);
      chk("ld_rvalid", 32'(ld_rvalid), mon_e.ld_rv);
      chk("f_rvalid",  32'(f_rvalid),  mon_e.f_rv);
      if (mon_e.mem_en != 0) begin
        chk("mem_addr", 32'(mem_addr), mon_e.addr);
        chk("mem_we",   32'(mem_we),   mon_e.mem_we);
        if (mon_e.mem_we != 0) chk("mem_wdata", mem_wdata, mon_e.wdata);
      end
      if (ld_rvalid) begin
        if (ld_q.size() == 0) chk("ld_rvalid_unexpected", 32'(ld_rvalid), 0);
        else                  chk("ld_rdata", ld_rdata, ld_q.pop_front());
      end
      if (f_rvalid) begin
        if (f_q.size() == 0) chk("f_rvalid_unexpected", 32'(f_rvalid), 0);
        else                 chk("f_rdata", f_rdata, f_q.pop_front());
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
    ram_q = '0;
    reset = 1;
    model_reset();
    zero_inputs();
    ld_req = 1; f_req = 1; ld_we = 1;
    @(negedge clk);
    chk("rst_ld_gnt",   32'(ld_gnt),   0);
    chk("rst_f_gnt",    32'(f_gnt),    0);
    chk("rst_mem_en",   32'(mem_en),   0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_halted",   32'(halted),   0);
    chk("rst_ld_rdata", ld_rdata,      0);
    chk("rst_f_rdata",  f_rdata,       0);
    zero_inputs();
    @(posedge clk);
    #1;
    reset = 0;

    // Boot load with fetch knocking, then readback and release.
    step(1, 1, 32'h0, 32'h0062E233, 0, 1, 32'h0);
    step(1, 1, 32'h4, 32'h00500113, 0, 1, 32'h0);
    step(1, 0, 32'h4, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h4);
    step(0, 0, 0, 0, 0, 0, 0);

    // Sustained contention: four loader wins, then one fetch.
    for (int i = 0; i < 20; i++)
      step(1, 1'($urandom_range(0, 1)), rnd_word_addr(), $urandom, 0, 1, rnd_word_addr());
    step(0, 0, 0, 0, 0, 0, 0);

    // Write then immediate fetch of the same word.
    step(1, 1, 32'h24, 32'hFE420AE3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h24);
    step(0, 0, 0, 0, 0, 0, 0);

    // Illegal loader addresses.
    step(1, 0, 32'h0000_1000, 0, 0, 0, 0);
    step(1, 1, 32'h0000_0003, 32'hDEAD_BEEF, 0, 1, 32'h8);
    step(1, 0, 32'h8000_0000, 0, 0, 1, 32'h8);

    // Random traffic in RUN; fetch addresses stay legal.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] la;
      la = ($urandom_range(0, 7) == 0) ? $urandom : rnd_word_addr();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), la, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_word_addr());
    end
    step(0, 0, 0, 0, 0, 0, 0);

    // Misaligned fetch parks the core; loader still serviced.
    step(0, 0, 0, 0, 0, 1, 32'h2);
    step(1, 0, 32'h24, 0, 0, 1, 32'h0);
    for (int i = 0; i < 30; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_word_addr(), $urandom,
           1'($urandom_range(0, 1)), 1, rnd_word_addr());
    step(1, 0, 32'h4, 0, 0, 1, 32'h4);

    // Reboot with a write in the ld_done cycle, then an out-of-range fetch.
    do_reset();
    step(1, 1, 32'h100, 32'h1234_5678, 1, 1, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 0, 1, 32'h1000);
    step(1, 0, 32'h100, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset while a loader read is in flight.
    do_reset();
    step(1, 0, 32'h100, 0, 0, 0, 0);
    #2;
    zero_inputs();
    reset = 1;
    model_reset();
    #1;
    chk("rstpend_ld_gnt", 32'(ld_gnt), 0);
    chk("rstpend_mem_en", 32'(mem_en), 0);
    @(posedge clk);
    #1;
    chk("rstpend_ld_rvalid", 32'(ld_rvalid), 0);
    chk("rstpend_cpu_hold",  32'(cpu_hold),  1);
    @(posedge clk);
    #1;
    reset = 0;
    step(0, 0, 0, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 0, 1, 32'h100);
    step(1, 0, 32'h100, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    chk("drain_exp_q", 32'(exp_q.size()), 0);
    chk("drain_ld_q",  32'(ld_q.size()),  0);
    chk("drain_f_q",   32'(f_q.size()),   0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
